// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared definitions for the multicycle MIPS control unit: the FSM
//            state enumeration, the opcode constants and the ALUOp constants.
// Config   : MULTICYCLE_CONTROL_BNE_EN -- adds the BNE state to the enum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  // Encodings are pinned so that the BNE slot stays reserved (and unused)
  // when the branch-not-equal feature is compiled out.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
`ifdef MULTICYCLE_CONTROL_BNE_EN
    BNE    = 4'd10,
`endif
    ADDIEX = 4'd11,
    SLTIEX = 4'd12,
    IMMWB  = 4'd13,
    JUMP   = 4'd14,
    ILL    = 4'd15
  } state_t;

  // Opcode field values
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  // ALU control classes
  localparam logic [2:0] c_aluop_add   = 3'b000;
  localparam logic [2:0] c_aluop_beq   = 3'b001;
  localparam logic [2:0] c_aluop_rtype = 3'b010;
  localparam logic [2:0] c_aluop_addi  = 3'b011;
  localparam logic [2:0] c_aluop_slti  = 3'b100;
  localparam logic [2:0] c_aluop_bne   = 3'b101;

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// Module   : mc_output_decode
// Purpose  : Combinational state-to-control-word decode for the multicycle
//            control FSM. Every output defaults to 0; each state raises only
//            its own controls.
// Ports    : i_state      - current FSM state
//            i_mem_ready  - memory completes this cycle (qualifies the
//                           FETCH-cycle IR/PC load)
//            o_*          - control word fields, see multicycle_control
// Config   : MULTICYCLE_CONTROL_BNE_EN -- decodes the BNE state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic        i_mem_ready,
  output logic        o_pcwrite,
  output logic        o_pcwritecond,
  output logic        o_branchne,
  output logic        o_iord,
  output logic        o_memread,
  output logic        o_memwrite,
  output logic        o_irwrite,
  output logic        o_regdst,
  output logic        o_memtoreg,
  output logic        o_regwrite,
  output logic        o_alusrca,
  output logic [1:0]  o_alusrcb,
  output logic [1:0]  o_pcsource,
  output logic [2:0]  o_aluop,
  output logic        o_illegal
);

  always_comb begin
    o_pcwrite     = 1'b0;
    o_pcwritecond = 1'b0;
    o_branchne    = 1'b0;
    o_iord        = 1'b0;
    o_memread     = 1'b0;
    o_memwrite    = 1'b0;
    o_irwrite     = 1'b0;
    o_regdst      = 1'b0;
    o_memtoreg    = 1'b0;
    o_regwrite    = 1'b0;
    o_alusrca     = 1'b0;
    o_alusrcb     = 2'b00;
    o_pcsource    = 2'b00;
    o_aluop       = c_aluop_add;
    o_illegal     = 1'b0;

    case (i_state)
      FETCH: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        // IR and PC+4 are only committed on the cycle the read completes.
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
      end
      DECODE: begin
        o_alusrcb = 2'b11;
      end
      MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
      end
      MEMRD: begin
        o_iord    = 1'b1;
        o_memread = 1'b1;
      end
      MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
      end
      MEMWB: begin
        o_regwrite = 1'b1;
        o_memtoreg = 1'b1;
      end
      REXEC: begin
        o_alusrca = 1'b1;
        o_aluop   = c_aluop_rtype;
      end
      RWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      BEQ: begin
        o_alusrca     = 1'b1;
        o_pcwritecond = 1'b1;
        o_pcsource    = 2'b01;
        o_aluop       = c_aluop_beq;
      end
`ifdef MULTICYCLE_CONTROL_BNE_EN
      BNE: begin
        o_alusrca     = 1'b1;
        o_pcwritecond = 1'b1;
        o_pcsource    = 2'b01;
        o_aluop       = c_aluop_bne;
        o_branchne    = 1'b1;
      end
`endif
      ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_aluop   = c_aluop_addi;
      end
      SLTIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_aluop   = c_aluop_slti;
      end
      IMMWB: begin
        o_regwrite = 1'b1;
      end
      JUMP: begin
        o_pcwrite  = 1'b1;
        o_pcsource = 2'b10;
      end
      ILL: begin
        o_illegal = 1'b1;
      end
      default: begin
        // IDLE and unused encodings keep the all-zero control word.
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle MIPS main control FSM. Holds the state register and
//            next-state logic; the control word is decoded from the state by
//            mc_output_decode.
// Ports    : clk, reset (async, active-high), Op[5:0] opcode, mem_ready;
//            outputs PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
//            IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0],
//            PCSource[1:0], ALUOp[2:0], Illegal.
// Config   : MULTICYCLE_CONTROL_BNE_EN -- decode opcode 000101 as BNE;
//            otherwise it is treated as an illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        BranchNe,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALUOp,
  output logic        Illegal
);

  state_t r_state;
  state_t w_next;
  logic   r_rst_hold;

  // Keeps the FSM in IDLE for the first edge after reset release, so the
  // first FETCH lands on the second rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rst_hold <= 1'b1;
    else       r_rst_hold <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_state <= IDLE;
    else if (r_rst_hold) r_state <= IDLE;
    else                 r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = FETCH;
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (Op)
          c_op_lw, c_op_sw: w_next = MEMADR;
          c_op_rtype:       w_next = REXEC;
          c_op_beq:         w_next = BEQ;
`ifdef MULTICYCLE_CONTROL_BNE_EN
          c_op_bne:         w_next = BNE;
`endif
          c_op_addi:        w_next = ADDIEX;
          c_op_slti:        w_next = SLTIEX;
          c_op_j:           w_next = JUMP;
          default:          w_next = ILL;
        endcase
      end
      // Op comes from the instruction register, so it is still the lw/sw
      // opcode here.
      MEMADR: w_next = (Op == c_op_lw) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) w_next = MEMWB;
      MEMWR:  if (mem_ready) w_next = FETCH;
      REXEC:  w_next = RWB;
      ADDIEX: w_next = IMMWB;
      SLTIEX: w_next = IMMWB;
      MEMWB, RWB, BEQ, IMMWB, JUMP, ILL: w_next = FETCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
      BNE:    w_next = FETCH;
`endif
      default: w_next = IDLE;
    endcase
  end

  mc_output_decode u_decode (
    .i_state       (r_state),
    .i_mem_ready   (mem_ready),
    .o_pcwrite     (PCWrite),
    .o_pcwritecond (PCWriteCond),
    .o_branchne    (BranchNe),
    .o_iord        (IorD),
    .o_memread     (MemRead),
    .o_memwrite    (MemWrite),
    .o_irwrite     (IRWrite),
    .o_regdst      (RegDst),
    .o_memtoreg    (MemtoReg),
    .o_regwrite    (RegWrite),
    .o_alusrca     (ALUSrcA),
    .o_alusrcb     (ALUSrcB),
    .o_pcsource    (PCSource),
    .o_aluop       (ALUOp),
    .o_illegal     (Illegal)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed, self-checking bench for multicycle_control. Expected
//            control words are queued per instruction and compared one per
//            cycle on the falling clock edge.
// Config   : MULTICYCLE_CONTROL_BNE_EN -- selects the expected bne behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
                IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                PCSource, ALUOp, Illegal};

  logic [18:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  string       tag;

  // Field order: pcw pcwc bne iord mrd mwr irw rdst m2r rw asa asb psrc aop ill
  function automatic logic [18:0] mk(
    input logic pcw, pcwc, bne, iord, mrd, mwr, irw, rdst, m2r, rw, asa,
    input logic [1:0] asb, input logic [1:0] psrc, input logic [2:0] aop,
    input logic ill);
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, rdst, m2r, rw, asa,
            asb, psrc, aop, ill};
  endfunction

  logic [18:0] cw_z, cw_f0, cw_f1, cw_d, cw_ma, cw_mr, cw_mw, cw_mwb;
  logic [18:0] cw_rx, cw_rwb, cw_beq, cw_bne, cw_ae, cw_se, cw_iwb, cw_j, cw_ill;

  task automatic check_now();
    logic [18:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s control word observed %h expected %h", tag, obs, e);
      end
    end
    checks++;
    assert ((MemRead & MemWrite) === 1'b0) else begin
      errors++;
      $error("FAIL %s rd_wr_excl observed %b expected 0", tag, MemRead & MemWrite);
    end
    checks++;
    assert ((RegWrite & PCWrite) === 1'b0) else begin
      errors++;
      $error("FAIL %s rw_pcw_excl observed %b expected 0", tag, RegWrite & PCWrite);
    end
  endtask

  task automatic step(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check_now();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cw_z   = '0;
    cw_f0  = mk(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b000,0);
    cw_f1  = mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b000,0);
    cw_d   = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0);
    cw_ma  = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0);
    cw_mr  = mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    cw_mw  = mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    cw_mwb = mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0);
    cw_rx  = mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0);
    cw_rwb = mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0);
    cw_beq = mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0);
    cw_bne = mk(0,1,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b101,0);
    cw_ae  = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b011,0);
    cw_se  = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0);
    cw_iwb = mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0);
    cw_j   = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0);
    cw_ill = mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1);

    // Reset state, then release: IDLE for one edge, FETCH on the second.
    reset = 1'b1; op = 6'b100011; mem_ready = 1'b0;
    tag = "reset";
    sb.push_back(cw_z); step(1'b0);
    tag = "release";
    @(negedge clk); reset = 1'b0; #1;
    sb.push_back(cw_z); check_now();
    sb.push_back(cw_z); step(1'b1);

    // lw, zero-wait: 5 cycles
    tag = "lw";
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_ma);
    sb.push_back(cw_mr); sb.push_back(cw_mwb);
    repeat (5) step(1'b1);

    // sw with three wait cycles in MEMWR
    tag = "sw";
    op = 6'b101011;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_ma);
    repeat (3) step(1'b1);
    repeat (3) begin sb.push_back(cw_mw); step(1'b0); end
    sb.push_back(cw_mw); step(1'b1);

    // FETCH wait states, then slti
    tag = "slti";
    op = 6'b001010;
    sb.push_back(cw_f0); sb.push_back(cw_f0); sb.push_back(cw_f1);
    sb.push_back(cw_d); sb.push_back(cw_se); sb.push_back(cw_iwb);
    step(1'b0); step(1'b0); repeat (4) step(1'b1);

    tag = "addi";
    op = 6'b001000;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_ae); sb.push_back(cw_iwb);
    repeat (4) step(1'b1);

    tag = "rtype";
    op = 6'b000000;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_rx); sb.push_back(cw_rwb);
    repeat (4) step(1'b1);

    tag = "beq";
    op = 6'b000100;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_beq);
    repeat (3) step(1'b1);

    tag = "j";
    op = 6'b000010;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_j);
    repeat (3) step(1'b1);

    tag = "bne";
    op = 6'b000101;
    sb.push_back(cw_f1); sb.push_back(cw_d);
`ifdef MULTICYCLE_CONTROL_BNE_EN
    sb.push_back(cw_bne);
`else
    sb.push_back(cw_ill);
`endif
    repeat (3) step(1'b1);

    // Unsupported opcode: one Illegal cycle, then back to FETCH
    tag = "illegal";
    op = 6'b111111;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_ill); sb.push_back(cw_f0);
    repeat (3) step(1'b1);
    step(1'b0);

    // Reset in the middle of a MEMRD wait
    tag = "reset_midwait";
    op = 6'b100011;
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_ma);
    sb.push_back(cw_mr); sb.push_back(cw_mr);
    step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    #1 reset = 1'b1; #1;
    sb.push_back(cw_z); check_now();
    sb.push_back(cw_z); step(1'b0);
    @(negedge clk); reset = 1'b0; op = 6'b000010; #1;
    sb.push_back(cw_z); check_now();
    sb.push_back(cw_z); step(1'b1);
    sb.push_back(cw_f1); sb.push_back(cw_d); sb.push_back(cw_j);
    repeat (3) step(1'b1);

    tag = "drain";
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s scoreboard left %0d expected 0", tag, sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
